// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered UART transmitter with configurable width, parity, stop bits and baud divisor
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int DATA_BITS = 8,
  parameter int PARITY = 0,
  parameter int STOP_BITS = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic in_valid,
  output logic in_ready,
  output logic tx,
  output logic busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [AW:0] FULL = FIFO_DEPTH[AW:0];
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;
  state_t state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [IW-1:0] bit_q, bit_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] cnt_q;
  logic par_q, par_d, stop_q, stop_d, tx_q, tx_d;
  logic push, pop, wrap, stop_end;
  logic [DATA_BITS-1:0] head;
  assign in_ready = !rst && cnt_q < FULL;
  assign push = in_valid && in_ready;
  assign head = mem[rp_q];
  assign wrap = baud_q == BW'(CLKS_PER_BIT - 1);
  assign stop_end = state_q == S_STOP && wrap && (STOP_BITS == 1 || stop_q);
  // Pop only when the line is free: idle, or on the very last edge of the stop period
  assign pop = cnt_q != '0 && (state_q == S_IDLE || stop_end);
  assign tx = tx_q;
  assign busy = state_q != S_IDLE;
  assign fifo_count = cnt_q;
  always_comb begin
    state_d = state_q;
    baud_d = (state_q == S_IDLE || wrap) ? '0 : baud_q + 1'b1;
    bit_d = bit_q;
    sh_d = sh_q;
    par_d = par_q;
    stop_d = stop_q;
    if (pop) begin
      state_d = S_START;
      sh_d = head;
      par_d = ^head ^ (PARITY == 1);
      stop_d = 1'b0;
    end else if (wrap) begin
      case (state_q)
        S_START: begin
          state_d = S_DATA;
          bit_d = '0;
        end
        S_DATA: begin
          state_d = (bit_q == IW'(DATA_BITS - 1)) ? (PARITY != 0 ? S_PAR : S_STOP) : S_DATA;
          bit_d = bit_q + 1'b1;
          sh_d = sh_q >> 1;
        end
        S_PAR: state_d = S_STOP;
        S_STOP: begin
          state_d = stop_end ? S_IDLE : S_STOP;
          stop_d = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end
    tx_d = state_d == S_START ? 1'b0 : state_d == S_DATA ? sh_d[0] : state_d == S_PAR ? par_d : 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      baud_q <= '0;
      bit_q <= '0;
      sh_q <= '0;
      par_q <= 1'b0;
      stop_q <= 1'b0;
      tx_q <= 1'b1;
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      baud_q <= baud_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      par_q <= par_d;
      stop_q <= stop_d;
      tx_q <= tx_d;
      wp_q <= wp_q + AW'(push);
      rp_q <= rp_q + AW'(pop);
      cnt_q <= cnt_q + (AW + 1)'(push) - (AW + 1)'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wp_q] <= in_data;
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: four configurations driven with directed words; a line monitor decodes frames against queued expectations
module tb_uart_tx_fifo;
  typedef struct packed {logic [12:0] f; int gap;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [8:0] d [4];
  logic [3:0] in_v = '0;
  logic [3:0] rdy, tx_w, busy_w;
  logic [2:0] cnt [4];
  int vec = 0, err = 0;
  exp_t exp_q [4][$];
  always #5 clk = ~clk;
  uart_tx_fifo #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) u0 (.clk(clk), .rst(rst), .in_data(d[0][7:0]), .in_valid(in_v[0]),
    .in_ready(rdy[0]), .tx(tx_w[0]), .busy(busy_w[0]), .fifo_count(cnt[0]));
  uart_tx_fifo #(.CLKS_PER_BIT(4), .PARITY(1)) u1 (.clk(clk), .rst(rst), .in_data(d[1][7:0]), .in_valid(in_v[1]),
    .in_ready(rdy[1]), .tx(tx_w[1]), .busy(busy_w[1]), .fifo_count(cnt[1]));
  uart_tx_fifo #(.CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(2)) u2 (.clk(clk), .rst(rst), .in_data(d[2][7:0]), .in_valid(in_v[2]),
    .in_ready(rdy[2]), .tx(tx_w[2]), .busy(busy_w[2]), .fifo_count(cnt[2]));
  uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(9), .PARITY(2)) u3 (.clk(clk), .rst(rst), .in_data(d[3]), .in_valid(in_v[3]),
    .in_ready(rdy[3]), .tx(tx_w[3]), .busy(busy_w[3]), .fifo_count(cnt[3]));
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    vec++;
    if (a !== e) begin
      err++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic expect_frame(input int l, input logic [12:0] f, input int g);
    exp_t e;
    e.f = f;
    e.gap = g;
    exp_q[l].push_back(e);
  endtask
  task automatic push_wait(input logic [8:0] v, output int w);
    w = 0;
    d[0] = v;
    in_v[0] = 1'b1;
    while (!rdy[0] && w < 100) begin
      tick;
      w++;
    end
    if (w == 100) chk("push_timeout", 32'(w), 0);
    tick;
    in_v[0] = 1'b0;
  endtask
  // Line monitor: samples each bit mid-period, decodes a whole frame, then checks against the lane's queue
  int cyc [4], last [4], gapv [4];
  bit inf [4];
  logic [12:0] fr [4];
  int now = 0;
  int nb [4] = '{10, 11, 12, 12};
  initial begin
    for (int i = 0; i < 4; i++) begin
      inf[i] = 1'b0;
      last[i] = 0;
    end
    forever begin
      @(negedge clk);
      now++;
      for (int i = 0; i < 4; i++) begin
        if (rst) inf[i] = 1'b0;
        else if (!inf[i] && tx_w[i] == 1'b0) begin
          inf[i] = 1'b1;
          cyc[i] = 0;
          fr[i] = '0;
          gapv[i] = now - last[i];
          last[i] = now;
        end
        if (inf[i]) begin
          if (cyc[i] % 4 == 2) fr[i][cyc[i] / 4] = tx_w[i];
          if (cyc[i] == 4 * nb[i] - 1) begin
            exp_t e;
            inf[i] = 1'b0;
            vec++;
            if (exp_q[i].size() == 0) begin
              err++;
              $display("FAIL frame lane%0d: got unexpected frame %0h expected none", i, fr[i]);
            end else begin
              e = exp_q[i].pop_front();
              if (fr[i] !== e.f || (e.gap != 0 && gapv[i] != e.gap)) begin
                err++;
                $display("FAIL frame lane%0d: got %0h gap %0d expected %0h gap %0d", i, fr[i], gapv[i], e.f, e.gap);
              end
            end
          end else cyc[i]++;
        end
      end
    end
  end
  initial begin
    int w;
    int n [4];
    for (int i = 0; i < 4; i++) d[i] = '0;
    repeat (3) tick;
    chk("rst_tx", 32'(tx_w[0]), 1);
    chk("rst_busy", 32'(busy_w[0]), 0);
    chk("rst_cnt", 32'(cnt[0]), 0);
    chk("rst_rdy", 32'(rdy[0]), 0);
    rst = 1'b0;
    #1;
    chk("rdy_after_rst", 32'(rdy[0]), 1);
    d[0] = 9'h0A5;
    in_v[0] = 1'b1;
    expect_frame(0, 13'h34A, 0);
    tick;
    in_v[0] = 1'b0;
    chk("accept_cnt", 32'(cnt[0]), 1);
    chk("accept_busy", 32'(busy_w[0]), 0);
    chk("accept_tx", 32'(tx_w[0]), 1);
    tick;
    chk("pop_cnt", 32'(cnt[0]), 0);
    chk("pop_busy", 32'(busy_w[0]), 1);
    chk("pop_tx", 32'(tx_w[0]), 0);
    repeat (39) tick;
    chk("busy_end_of_frame", 32'(busy_w[0]), 1);
    tick;
    chk("busy_dropped", 32'(busy_w[0]), 0);
    repeat (5) tick;
    d[1] = 9'h003;
    d[2] = 9'h003;
    d[3] = 9'h1FF;
    in_v[3:1] = 3'b111;
    expect_frame(1, 13'h0606, 0);
    expect_frame(2, 13'h0C06, 0);
    expect_frame(3, 13'h0FFE, 0);
    tick;
    in_v = '0;
    for (int i = 0; i < 4; i++) n[i] = 0;
    for (int k = 0; k < 200; k++) begin
      tick;
      for (int i = 0; i < 4; i++) if (busy_w[i]) n[i]++;
    end
    chk("len_8n1_idle", 32'(n[0]), 0);
    chk("len_odd", 32'(n[1]), 44);
    chk("len_even_2stop", 32'(n[2]), 48);
    chk("len_9bit_even", 32'(n[3]), 48);
    expect_frame(0, 13'h0222, 0);
    expect_frame(0, 13'h0244, 40);
    expect_frame(0, 13'h0266, 40);
    expect_frame(0, 13'h0288, 40);
    expect_frame(0, 13'h02AA, 40);
    expect_frame(0, 13'h02CC, 40);
    push_wait(9'h011, w);
    push_wait(9'h022, w);
    push_wait(9'h033, w);
    push_wait(9'h044, w);
    push_wait(9'h055, w);
    chk("full_cnt", 32'(cnt[0]), 4);
    chk("full_rdy", 32'(rdy[0]), 0);
    push_wait(9'h066, w);
    chk("full_refusal_cycles", 32'(w), 37);
    repeat (260) tick;
    chk("drain_busy", 32'(busy_w[0]), 0);
    push_wait(9'h0FF, w);
    push_wait(9'h012, w);
    push_wait(9'h034, w);
    repeat (16) tick;
    chk("pre_rst_cnt", 32'(cnt[0]), 2);
    chk("pre_rst_busy", 32'(busy_w[0]), 1);
    rst = 1'b1;
    d[0] = 9'h077;
    in_v[0] = 1'b1;
    tick;
    chk("midrst_tx", 32'(tx_w[0]), 1);
    chk("midrst_cnt", 32'(cnt[0]), 0);
    chk("midrst_busy", 32'(busy_w[0]), 0);
    chk("midrst_rdy", 32'(rdy[0]), 0);
    rst = 1'b0;
    in_v[0] = 1'b0;
    repeat (60) tick;
    chk("post_rst_cnt", 32'(cnt[0]), 0);
    chk("post_rst_busy", 32'(busy_w[0]), 0);
    chk("post_rst_tx", 32'(tx_w[0]), 1);
    for (int i = 0; i < 4; i++) chk($sformatf("pending_lane%0d", i), 32'(exp_q[i].size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
